// File: rtl/spi_master_arbiter_if.sv
// Bundle between the round-robin SPI arbiter, its requesters and the shared spi_master.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface spi_master_arbiter_if #(
    parameter int REQ_COUNT       = 4,
    parameter int SLAVE_ADDRS_LEN = 3
);
    logic [REQ_COUNT-1:0]                 i_req;
    logic [REQ_COUNT*SLAVE_ADDRS_LEN-1:0] i_req_chip;
    logic [REQ_COUNT*32-1:0]              i_req_tx;
    logic [REQ_COUNT*2-1:0]               i_req_len;
    logic [REQ_COUNT*2-1:0]               i_req_mode;
    logic [REQ_COUNT*4-1:0]               i_req_div;
    logic [REQ_COUNT-1:0]                 o_gnt;
    logic [REQ_COUNT-1:0]                 o_done;
    logic [31:0]                          o_rx_out;
    logic                                 o_m_start;
    logic                                 i_m_busy;
    logic [31:0]                          i_m_rx_data;
    logic [SLAVE_ADDRS_LEN-1:0]           o_m_chip;
    logic [31:0]                          o_m_tx;
    logic [1:0]                           o_m_len;
    logic [3:0]                           o_m_div;
    logic                                 o_m_cpol;
    logic                                 o_m_cpha;

    modport slave (
        input  i_req, i_req_chip, i_req_tx, i_req_len, i_req_mode, i_req_div,
        input  i_m_busy, i_m_rx_data,
        output o_gnt, o_done, o_rx_out, o_m_start,
        output o_m_chip, o_m_tx, o_m_len, o_m_div, o_m_cpol, o_m_cpha
    );

    modport master (
        output i_req, i_req_chip, i_req_tx, i_req_len, i_req_mode, i_req_div,
        output i_m_busy, i_m_rx_data,
        input  o_gnt, o_done, o_rx_out, o_m_start,
        input  o_m_chip, o_m_tx, o_m_len, o_m_div, o_m_cpol, o_m_cpha
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master among REQ_COUNT requesters.
// The master configuration is latched at grant time and held for the whole transfer.
module spi_master_arbiter #(
    parameter int REQ_COUNT       = 4,
    parameter int SLAVE_ADDRS_LEN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_master_arbiter_if.slave  bus
);
    localparam int IDX_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam logic [REQ_COUNT-1:0] ONE_HOT0 = {{(REQ_COUNT-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           r_last;
    logic [REQ_COUNT-1:0]       r_gnt;
    logic [REQ_COUNT-1:0]       r_done;
    logic [31:0]                r_rx_out;
    logic                       r_m_start;
    logic [SLAVE_ADDRS_LEN-1:0] r_m_chip;
    logic [31:0]                r_m_tx;
    logic [1:0]                 r_m_len;
    logic [3:0]                 r_m_div;
    logic                       r_m_cpol;
    logic                       r_m_cpha;

    logic [SLAVE_ADDRS_LEN-1:0] w_chip [REQ_COUNT];
    logic [31:0]                w_tx   [REQ_COUNT];
    logic [1:0]                 w_len  [REQ_COUNT];
    logic [1:0]                 w_mode [REQ_COUNT];
    logic [3:0]                 w_div  [REQ_COUNT];
    logic                       w_found;
    logic [IDX_W-1:0]           w_win;
    logic [IDX_W-1:0]           w_cand;

    for (genvar g = 0; g < REQ_COUNT; g++) begin : g_unpack
        assign w_chip[g] = bus.i_req_chip[g*SLAVE_ADDRS_LEN +: SLAVE_ADDRS_LEN];
        assign w_tx[g]   = bus.i_req_tx[g*32 +: 32];
        assign w_len[g]  = bus.i_req_len[g*2 +: 2];
        assign w_mode[g] = bus.i_req_mode[g*2 +: 2];
        assign w_div[g]  = bus.i_req_div[g*4 +: 4];
    end

    // Round-robin search: first pending requester starting just after the last owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            w_cand = IDX_W'((int'(r_last) + 32'sd1 + k) % REQ_COUNT);
            if (!w_found && bus.i_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Transaction sequencer; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_last    <= IDX_W'(REQ_COUNT - 1);
            r_gnt     <= '0;
            r_done    <= '0;
            r_rx_out  <= 32'h0000_0000;
            r_m_start <= 1'b0;
            r_m_chip  <= '0;
            r_m_tx    <= 32'h0000_0000;
            r_m_len   <= 2'b00;
            r_m_div   <= 4'h0;
            r_m_cpol  <= 1'b0;
            r_m_cpha  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found && !bus.i_m_busy) begin
                        r_m_chip <= w_chip[w_win];
                        r_m_tx   <= w_tx[w_win];
                        r_m_len  <= w_len[w_win];
                        r_m_div  <= w_div[w_win];
                        r_m_cpol <= w_mode[w_win][1];
                        r_m_cpha <= w_mode[w_win][0];
                        r_gnt    <= ONE_HOT0 << w_win;
                        r_idx    <= w_win;
                        r_state  <= S_SETUP;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                // Extra cycle lets the new CPOL settle SCLK before the master starts.
                S_SETUP: begin
                    r_m_start <= 1'b1;
                    r_state   <= S_START;
                end
                S_START: begin
                    if (bus.i_m_busy) begin
                        r_m_start <= 1'b0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_state   <= S_START;
                    end
                end
                S_WAIT: begin
                    if (!bus.i_m_busy) begin
                        r_rx_out <= bus.i_m_rx_data;
                        r_done   <= r_gnt;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_WAIT;
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_last  <= r_idx;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done    <= '0;
                    r_gnt     <= '0;
                    r_m_start <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_gnt     = r_gnt;
    assign bus.o_done    = r_done;
    assign bus.o_rx_out  = r_rx_out;
    assign bus.o_m_start = r_m_start;
    assign bus.o_m_chip  = r_m_chip;
    assign bus.o_m_tx    = r_m_tx;
    assign bus.o_m_len   = r_m_len;
    assign bus.o_m_div   = r_m_div;
    assign bus.o_m_cpol  = r_m_cpol;
    assign bus.o_m_cpha  = r_m_cpha;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a small behavioural spi_master model.
module tb_spi_master_arbiter;
    logic clk;
    logic rst;
    logic force_busy;
    int   checks;
    int   errors;

    spi_master_arbiter_if #(.REQ_COUNT(4), .SLAVE_ADDRS_LEN(3)) bus ();

    spi_master_arbiter #(.REQ_COUNT(4), .SLAVE_ADDRS_LEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Master model: busy follows start immediately, transfer lasts 6+4*len cycles.
    logic        r_mb;
    int          r_cnt;
    logic [31:0] r_mrx;
    logic [31:0] slave_rx [8];

    assign bus.i_m_busy    = r_mb | bus.o_m_start | force_busy;
    assign bus.i_m_rx_data = r_mrx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mb  <= 1'b0;
            r_cnt <= 0;
            r_mrx <= 32'h0;
        end else if (!r_mb && bus.o_m_start) begin
            r_mb  <= 1'b1;
            r_cnt <= 6 + 4 * int'(bus.o_m_len);
        end else if (r_mb) begin
            if (r_cnt == 1) begin
                r_mb  <= 1'b0;
                r_mrx <= slave_rx[bus.o_m_chip];
            end else begin
                r_cnt <= r_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag, input logic [3:0] exp);
        tick();
        for (int i = 0; i < 60; i++) begin
            if (bus.o_gnt == 4'b0000) tick();
        end
        chk(tag, {28'h0, bus.o_gnt}, {28'h0, exp});
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp, input logic [31:0] rx);
        for (int i = 0; i < 100; i++) begin
            if (bus.o_done == 4'b0000) tick();
        end
        chk({tag, "_done"}, {28'h0, bus.o_done}, {28'h0, exp});
        chk({tag, "_rx"}, bus.o_rx_out, rx);
    endtask

    logic [1:0] mode_exp [4];
    logic [31:0] rx_exp  [4];
    logic [3:0]  oh;

    initial begin
        clk = 1'b0; rst = 1'b1; force_busy = 1'b0;
        checks = 0; errors = 0;
        for (int i = 0; i < 8; i++) slave_rx[i] = 32'h0;
        slave_rx[2] = 32'h0000_003C;
        slave_rx[5] = 32'hDEAD_BEEF;
        slave_rx[6] = 32'h0000_0066;
        slave_rx[7] = 32'h0000_0077;
        mode_exp[0] = 2'b00; mode_exp[1] = 2'b11; mode_exp[2] = 2'b00; mode_exp[3] = 2'b01;
        rx_exp[0] = 32'h0000_003C; rx_exp[1] = 32'hDEAD_BEEF;
        rx_exp[2] = 32'h0000_0066; rx_exp[3] = 32'h0000_0077;
        bus.i_req      = 4'b0000;
        bus.i_req_chip = {3'd7, 3'd6, 3'd5, 3'd2};
        bus.i_req_tx   = {32'h0000_3333, 32'h0000_0055, 32'h1234_5678, 32'h0000_00A5};
        bus.i_req_len  = {2'b01, 2'b00, 2'b11, 2'b00};
        bus.i_req_mode = {2'b01, 2'b00, 2'b11, 2'b00};
        bus.i_req_div  = {4'd1, 4'd0, 4'd3, 4'd0};

        // Reset state
        repeat (3) tick();
        chk("rst_gnt",   {28'h0, bus.o_gnt},  32'h0);
        chk("rst_done",  {28'h0, bus.o_done}, 32'h0);
        chk("rst_rx",    bus.o_rx_out,        32'h0);
        chk("rst_start", {31'h0, bus.o_m_start}, 32'h0);
        chk("rst_tx",    bus.o_m_tx,          32'h0);
        rst = 1'b0;
        tick();

        // Single request: grant one edge after req, start the edge after, one-cycle start
        bus.i_req = 4'b0001;
        tick();
        chk("single_gnt",   {28'h0, bus.o_gnt}, 32'h1);
        chk("single_chip",  {29'h0, bus.o_m_chip}, 32'h2);
        chk("single_tx",    bus.o_m_tx, 32'h0000_00A5);
        chk("single_nost",  {31'h0, bus.o_m_start}, 32'h0);
        tick();
        chk("single_start", {31'h0, bus.o_m_start}, 32'h1);
        tick();
        chk("single_stoff", {31'h0, bus.o_m_start}, 32'h0);
        wait_done("single", 4'b0001, 32'h0000_003C);
        chk("single_gnt_in_done", {28'h0, bus.o_gnt}, 32'h1);
        bus.i_req = 4'b0000;
        tick();
        chk("single_done_clr", {28'h0, bus.o_done}, 32'h0);
        chk("single_gnt_clr",  {28'h0, bus.o_gnt},  32'h0);

        // Simultaneous requests after a fresh reset: order 0,1,2,3,0; mode isolation
        rst = 1'b1; #2; rst = 1'b0;
        bus.i_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            wait_gnt($sformatf("rr_gnt%0d", k), oh);
            chk($sformatf("rr_mode%0d", k), {30'h0, bus.o_m_cpol, bus.o_m_cpha},
                {30'h0, mode_exp[k % 4]});
            tick();
            chk($sformatf("rr_start%0d", k), {30'h0, bus.o_m_start, bus.o_m_cpol},
                {30'h0, 1'b1, mode_exp[k % 4][1]});
            wait_done($sformatf("rr%0d", k), oh, rx_exp[k % 4]);
            chk($sformatf("rr_mode_hold%0d", k), {30'h0, bus.o_m_cpol, bus.o_m_cpha},
                {30'h0, mode_exp[k % 4]});
        end
        bus.i_req = 4'b0000;

        // Request drop: requester 3 releases 5 cycles into WAIT, requester 1 then pending
        bus.i_req = 4'b1000;
        wait_gnt("drop_gnt3", 4'b1000);
        repeat (2) tick();
        repeat (5) tick();
        bus.i_req = 4'b0010;
        wait_done("drop3", 4'b1000, 32'h0000_0077);
        wait_gnt("drop_gnt1", 4'b0010);
        wait_done("drop1", 4'b0010, 32'hDEAD_BEEF);
        bus.i_req = 4'b0000;

        // Reset in WAIT: everything clears, then requester 0 wins over 3
        bus.i_req = 4'b0100;
        wait_gnt("mid_gnt2", 4'b0100);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("mid_gnt",   {28'h0, bus.o_gnt},  32'h0);
        chk("mid_done",  {28'h0, bus.o_done}, 32'h0);
        chk("mid_rx",    bus.o_rx_out,        32'h0);
        chk("mid_chip",  {29'h0, bus.o_m_chip}, 32'h0);
        chk("mid_start", {31'h0, bus.o_m_start}, 32'h0);
        bus.i_req = 4'b1001;
        @(negedge clk);
        rst = 1'b0;
        wait_gnt("mid_first", 4'b0001);
        wait_done("mid_r0", 4'b0001, 32'h0000_003C);
        bus.i_req = 4'b1000;
        wait_gnt("mid_second", 4'b1000);
        wait_done("mid_r3", 4'b1000, 32'h0000_0077);
        bus.i_req = 4'b0000;

        // Busy master while idle: no grant until busy clears
        tick();
        force_busy = 1'b1;
        bus.i_req  = 4'b0010;
        repeat (5) tick();
        chk("busy_nogrant", {28'h0, bus.o_gnt}, 32'h0);
        chk("busy_nostart", {31'h0, bus.o_m_start}, 32'h0);
        force_busy = 1'b0;
        wait_gnt("busy_gnt", 4'b0010);
        chk("busy_div", {28'h0, bus.o_m_div}, 32'h3);
        wait_done("busy", 4'b0010, 32'hDEAD_BEEF);
        bus.i_req = 4'b0000;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
